// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Optional performance counters are enabled with the PIPE_PERF_CNT_EN macro.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RESET_S = 2'd0,
    RUN     = 2'd1,
    WAIT    = 2'd2
  } pipe_state_t;

  localparam int          REG_ADDR_W = 5;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Controller <-> datapath bundle: memory handshakes, hazard operands and stage enables.
// Handshake: imem_resp/dmem_resp are single-cycle pulses; a stage register captures only when its load is 1.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic                  imem_resp;
  logic                  dmem_req;
  logic                  dmem_resp;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_is_load;
  logic                  redirect;

  logic imem_read;
  logic pc_load;
  logic if_id_load;
  logic if_id_flush;
  logic id_ex_load;
  logic id_ex_flush;
  logic ex_mem_load;
  logic mem_wb_load;

  modport master (
    input  imem_resp, dmem_req, dmem_resp, id_rs1, id_rs2, ex_rd, ex_is_load, redirect,
    output imem_read, pc_load, if_id_load, if_id_flush, id_ex_load, id_ex_flush,
           ex_mem_load, mem_wb_load
  );

  modport slave (
    output imem_resp, dmem_req, dmem_resp, id_rs1, id_rs2, ex_rd, ex_is_load, redirect,
    input  imem_read, pc_load, if_id_load, if_id_flush, id_ex_load, id_ex_flush,
           ex_mem_load, mem_wb_load
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detection between the instruction in ID and a load in EX.
// Kept separate so forwarding detection can be added alongside later.
module pipeline_ctrl_hazard_detect
  import pipeline_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_is_load_i,
    output logic                  load_use_o
);

    // x0 is never written, so a load targeting it cannot create a dependency.
    assign load_use_o = ex_is_load_i & (ex_rd_i != '0) &
                        ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencing controller: freezes on outstanding memory, bubbles load-use, squashes on redirect.
// Define PIPE_PERF_CNT_EN to build the stall/bubble/squash counters; otherwise they read 0.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    pipeline_ctrl_if.master  bus,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    pipe_state_t state_q;
    logic        i_done_q;
    logic        d_done_q;
    logic        squash_q;
    logic        running;
    logic        advance;
    logic        load_use;
    logic        bubble;

    pipeline_ctrl_hazard_detect u_hazard (
        .id_rs1_i     (bus.id_rs1),
        .id_rs2_i     (bus.id_rs2),
        .ex_rd_i      (bus.ex_rd),
        .ex_is_load_i (bus.ex_is_load),
        .load_use_o   (load_use)
    );

    assign running = (state_q != RESET_S);
    assign advance = running & (bus.imem_resp | i_done_q) &
                     (~bus.dmem_req | bus.dmem_resp | d_done_q);
    // Redirect wins: the ID instruction is squashed anyway, so stalling for it is pointless.
    assign bubble  = advance & load_use & ~bus.redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RESET_S;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            squash_q <= 1'b1;
        end else begin
            case (state_q)
                RESET_S: state_q <= RUN;
                RUN,
                WAIT:    state_q <= advance ? RUN : WAIT;
                default: state_q <= RESET_S;
            endcase
            if (advance) begin
                i_done_q <= 1'b0;
                d_done_q <= 1'b0;
                squash_q <= bus.redirect;
            end else if (running) begin
                // Remember each response so split arrivals still release the freeze.
                i_done_q <= i_done_q | bus.imem_resp;
                d_done_q <= d_done_q | bus.dmem_resp;
            end
        end
    end

    assign bus.imem_read   = running;
    assign bus.pc_load     = advance & ~bubble;
    assign bus.if_id_load  = advance & ~bubble;
    assign bus.if_id_flush = squash_q;
    assign bus.id_ex_load  = advance;
    assign bus.id_ex_flush = advance & (load_use | bus.redirect);
    assign bus.ex_mem_load = advance;
    assign bus.mem_wb_load = advance;
    assign state           = state_q;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] stall_q,  stall_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

    always_comb begin
        stall_d      = stall_q;
        bubble_d     = bubble_q;
        squash_cnt_d = squash_cnt_q;
        if (running && !advance && stall_q != '1)
            stall_d = stall_q + CNT_ONE;
        if (bubble && bubble_q != '1)
            bubble_d = bubble_q + CNT_ONE;
        if (advance && bus.redirect && squash_cnt_q != '1)
            squash_cnt_d = squash_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q      <= '0;
            bubble_q     <= '0;
            squash_cnt_q <= '0;
        end else begin
            stall_q      <= stall_d;
            bubble_q     <= bubble_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
    assign squash_cnt = squash_cnt_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
    assign squash_cnt = '0;
`endif

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Sequencing controller for the 5-stage pipeline: drives load/flush of if_id_reg, id_ex_reg, ex_mem_reg, mem_wb_reg and the PC load enable.
- Freezes the whole pipeline while instruction or data memory responses are outstanding.
- Inserts a load-use bubble when needed, and squashes wrong-path instructions when a branch or jump redirect resolves in EX.
- Sits beside the datapath top; the datapath owns all muxes and the controller owns all enables.

Parameters:
CNT_W, 32, width of performance counters (used only with PIPE_PERF_CNT_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_resp  in  1  1-cycle pulse: fetch data valid for current PC
dmem_req  in  1  instruction in MEM stage reads or writes memory (from EX/MEM control word)
dmem_resp  in  1  1-cycle pulse: data access complete
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
ex_rd  in  5  rd of instruction in EX
ex_is_load  in  1  EX instruction is a load
redirect  in  1  EX resolved taken branch/jal/jalr; PC mux already selects target
imem_read  out  1  fetch request for current PC
pc_load  out  1  PC register enable
if_id_load  out  1  IF/ID enable
if_id_flush  out  1  IF/ID output forced to NOP (0x00000013)
id_ex_load  out  1  ID/EX enable
id_ex_flush  out  1  zero control word on ID/EX load
ex_mem_load  out  1  EX/MEM enable
mem_wb_load  out  1  MEM/WB enable
state  out  2  current FSM state, for debug
stall_cnt, bubble_cnt, squash_cnt  out  CNT_W each  performance counters

Behaviour:
- States: RESET_S=0, RUN=1, WAIT=2. Reset drives state=RESET_S, i_done=0, d_done=0, squash_q=1. All loads are 0 and imem_read=0 while rst_n=0. if_id_flush=1 and id_ex_flush=0 under reset.
- RESET_S -> RUN on the first clk edge after rst_n deasserts. imem_read=1 in RUN and WAIT.
- advance = (imem_resp | i_done) & (~dmem_req | dmem_resp | d_done). It is combinational and is 0 in RESET_S.
- i_done is set on imem_resp when advance=0. d_done is set on dmem_resp when advance=0. Both clear when advance=1. Responses arriving on different cycles are therefore both remembered.
- RUN -> WAIT when advance=0. WAIT -> RUN when advance=1. advance=1 in RUN keeps RUN.
- advance=0: every load is 0, id_ex_flush=0, and the pipeline is frozen.
- advance=1, no hazard: pc_load, if_id_load, id_ex_load, ex_mem_load and mem_wb_load are all 1.
- Load-use hazard: lu = ex_is_load & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2). On advance & lu & ~redirect:
  - pc_load=0, if_id_load=0;
  - id_ex_load=1 with id_ex_flush=1 (bubble);
  - ex_mem_load=1, mem_wb_load=1.
- Redirect: on advance & redirect, all loads are 1 and id_ex_flush=1 (the ID instruction is squashed). squash_q is set; it clears on the next advance without redirect.
- if_id_flush = squash_q, so the wrong-path fetch now in IF/ID reads as NOP until the next advance replaces it.
- Redirect has priority over load-use.
- Latency: zero-cycle combinational enables from inputs, plus one-cycle registered squash.
- rst_n asserted mid-WAIT abandons pending i_done/d_done immediately. Responses arriving during reset are ignored.

Optional Feature:
PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt increments each cycle with state!=RESET_S and advance=0;
  - bubble_cnt increments on each load-use bubble;
  - squash_cnt increments on each redirect advance.
  - All saturate at 2^CNT_W-1 and reset to 0.
- Undefined: the ports remain and are tied to 0; no counter flops exist.

Decomposition:
- rv32i_types gains pipe_state_t (RESET_S, RUN, WAIT) and the constant NOP_INSTR=32'h00000013.
- One sub-module: hazard_detect (combinational lu equation), so forwarding work can extend it later.

Test Plan:
- Reset: rst_n=0 for 3 cycles -> all loads 0, imem_read=0, if_id_flush=1, state=0. After release, one edge later state=1 and imem_read=1.
- Split responses, with dmem_req=1:
  - imem_resp at cycle 5 -> i_done=1, loads stay 0, state=2;
  - dmem_resp at cycle 8 -> all loads 1 in cycle 8 only, state returns 1 in cycle 9.
- Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, imem_resp=1 -> pc_load=0, if_id_load=0, id_ex_flush=1, ex_mem_load=1. Repeat with ex_rd=0 -> no bubble.
- Redirect: redirect=1 with advance -> all loads 1, id_ex_flush=1; next cycle if_id_flush=1. If the next advance is delayed 3 cycles, if_id_flush stays 1 throughout, then clears.
- Redirect plus load-use in the same cycle -> redirect behaviour, pc_load=1, no bubble.
- With PIPE_PERF_CNT_EN: 4 wait cycles, 2 bubbles, 1 redirect -> stall_cnt=4, bubble_cnt=2, squash_cnt=1. Without the macro all three read 0.
